// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests and
// buffers a single fetched instruction for decode; control-stage redirects squash wrong-path fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        redirect_misaligned
);

    typedef enum logic {S_REQ, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        squash_q, squash_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        mis_q, mis_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            squash_q   <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            squash_q   <= squash_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        squash_d   = squash_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        mis_d      = 1'b0;

        if (redirect_valid) begin
            // Redirect overrides everything, including a fill or consume this cycle.
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            mis_d      = |redirect_pc[1:0];
            if (state_q == S_WAIT) begin
                if (imem_rvalid) begin
                    squash_d = 1'b0;
                    state_d  = S_REQ;
                end else begin
                    squash_d = 1'b1;
                end
            end
        end else begin
            if (id_valid_q && id_ready) begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
            case (state_q)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        if (squash_q) begin
                            squash_d = 1'b0;
                        end else begin
                            id_valid_d = 1'b1;
                            id_instr_d = imem_rdata;
                            id_pc_d    = req_pc_q;
                        end
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem_req            = (state_q == S_REQ) && !rst && (!id_valid_q || id_ready) && !redirect_valid;
        imem_addr           = pc_q;
        id_valid            = id_valid_q;
        id_instr            = id_instr_q;
        id_pc               = id_pc_q;
        redirect_misaligned = mis_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-randomised instruction memory plus a transaction-level
// model of the fetch stream (in-flight request, kill flag, one-entry decode buffer).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_misaligned;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk                (clk),
        .rst                (rst),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_gnt           (imem_gnt),
        .imem_rvalid        (imem_rvalid),
        .imem_rdata         (imem_rdata),
        .id_valid           (id_valid),
        .id_instr           (id_instr),
        .id_pc              (id_pc),
        .id_ready           (id_ready),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .redirect_misaligned(redirect_misaligned)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Memory configuration: gnt_all ties grant high; lat_cfg==0 picks 1..3 cycles at random.
    bit          gnt_all = 1'b1;
    int          lat_cfg = 1;
    bit          mem_pending = 1'b0;
    int          mem_lat = 0;
    logic [31:0] mem_addr = '0;

    // Reference model state.
    logic [31:0] m_pc = RESET_PC;
    bit          m_inflight = 1'b0;
    bit          m_kill = 1'b0;
    logic [31:0] m_req_addr = '0;
    bit          buf_valid = 1'b0;
    logic [31:0] buf_instr = NOP_INSTR;
    logic [31:0] buf_pc = '0;
    bit          m_mis = 1'b0;
    bit          exp_req = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
    endfunction

    task automatic model_edge();
        bit granted;
        granted = exp_req && imem_gnt;
        if (rst) begin
            m_pc = RESET_PC; m_inflight = 0; m_kill = 0;
            buf_valid = 0; buf_instr = NOP_INSTR; buf_pc = '0; m_mis = 0;
            mem_pending = 0;
            return;
        end
        if (imem_rvalid) mem_pending = 0;
        else if (mem_pending && mem_lat > 0) mem_lat--;
        if (granted) begin
            mem_pending = 1;
            mem_addr = m_pc;
            mem_lat = (lat_cfg == 0) ? int'($urandom_range(0, 2)) : lat_cfg - 1;
        end
        if (redirect_valid) begin
            buf_valid = 0; buf_instr = NOP_INSTR;
            m_mis = |redirect_pc[1:0];
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            if (m_inflight) begin
                if (imem_rvalid) begin m_inflight = 0; m_kill = 0; end
                else m_kill = 1;
            end
        end else begin
            m_mis = 0;
            if (imem_rvalid && m_inflight && !m_kill) begin
                buf_valid = 1; buf_instr = instr_of(m_req_addr); buf_pc = m_req_addr;
            end else if (buf_valid && id_ready) begin
                buf_valid = 0; buf_instr = NOP_INSTR;
            end
            if (imem_rvalid && m_inflight) begin m_inflight = 0; m_kill = 0; end
            if (granted) begin m_inflight = 1; m_req_addr = m_pc; m_pc = m_pc + 32'd4; end
        end
    endtask

    // One clock: retire the previous cycle into the model, then drive this cycle's inputs.
    task automatic cyc(input logic rs, input logic rdy, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = rs; id_ready = rdy; redirect_valid = rv; redirect_pc = rp;
        imem_gnt = gnt_all ? 1'b1 : 1'($urandom_range(0, 1));
        imem_rvalid = mem_pending && (mem_lat == 0);
        imem_rdata = imem_rvalid ? instr_of(mem_addr) : $urandom;
        exp_req = !m_inflight && !rs && (!buf_valid || rdy) && !rv;
        assert (!(imem_rvalid && !m_inflight)) else $error("rvalid driven with no request in flight");
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 1, 0, '0);
        cyc(1, 1, 0, '0);
    endtask

    task automatic test_reset();
        gnt_all = 1; lat_cfg = 1;
        do_reset();
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        cyc(0, 0, 0, '0);
        nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        nvec++; if (id_instr !== NOP_INSTR) begin nerr++; $display("FAIL reset_instr got=%h exp=%h", id_instr, NOP_INSTR); end
        nvec++; if (id_pc !== 32'h0) begin nerr++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        nvec++; if (imem_addr !== RESET_PC) begin nerr++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
        nvec++; if (redirect_misaligned !== 1'b0) begin nerr++; $display("FAIL reset_mis got=%b exp=0", redirect_misaligned); end
    endtask

    task automatic test_stream();
        logic [31:0] next_pc;
        int delivered;
        gnt_all = 1; lat_cfg = 1; next_pc = RESET_PC; delivered = 0;
        do_reset();
        for (int unsigned i = 0; i < 14; i++) begin
            cyc(0, 1, 0, '0);
            nvec++; if (imem_req !== exp_req) begin nerr++; $display("FAIL stream_req c=%0d got=%b exp=%b", i, imem_req, exp_req); end
            nvec++; if (imem_addr !== m_pc) begin nerr++; $display("FAIL stream_addr c=%0d got=%h exp=%h", i, imem_addr, m_pc); end
            nvec++; if (id_valid !== buf_valid) begin nerr++; $display("FAIL stream_valid c=%0d got=%b exp=%b", i, id_valid, buf_valid); end
            if (id_valid === 1'b1) begin
                nvec++; if (id_pc !== next_pc) begin nerr++; $display("FAIL stream_seq c=%0d got=%h exp=%h", i, id_pc, next_pc); end
                nvec++; if (id_instr !== instr_of(next_pc)) begin nerr++; $display("FAIL stream_instr c=%0d got=%h exp=%h", i, id_instr, instr_of(next_pc)); end
                next_pc += 4; delivered++;
            end
        end
        nvec++; if (delivered < 6) begin nerr++; $display("FAIL stream_rate got=%0d exp>=6", delivered); end
    endtask

    task automatic test_stall();
        gnt_all = 1; lat_cfg = 1;
        do_reset();
        cyc(0, 1, 0, '0);
        cyc(0, 1, 0, '0);
        for (int unsigned i = 0; i < 6; i++) begin
            cyc(0, 0, 0, '0);
            nvec++; if (id_valid !== 1'b1) begin nerr++; $display("FAIL stall_valid c=%0d got=%b exp=1", i, id_valid); end
            nvec++; if (id_pc !== 32'h0) begin nerr++; $display("FAIL stall_pc c=%0d got=%h exp=0", i, id_pc); end
            nvec++; if (id_instr !== instr_of(32'h0)) begin nerr++; $display("FAIL stall_instr c=%0d got=%h exp=%h", i, id_instr, instr_of(32'h0)); end
            nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL stall_req c=%0d got=%b exp=0", i, imem_req); end
        end
        cyc(0, 1, 0, '0);
        nvec++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL stall_resume_req got=%b exp=1", imem_req); end
        nvec++; if (imem_addr !== 32'h4) begin nerr++; $display("FAIL stall_resume_addr got=%h exp=4", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        bit seen;
        gnt_all = 1; lat_cfg = 3; seen = 0;
        do_reset();
        cyc(0, 1, 0, '0);
        cyc(0, 1, 1, 32'h100);
        for (int unsigned i = 0; i < 2; i++) begin
            cyc(0, 1, 0, '0);
            nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL redir_drop_valid c=%0d got=%b exp=0", i, id_valid); end
            nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL redir_wait_req c=%0d got=%b exp=0", i, imem_req); end
        end
        cyc(0, 1, 0, '0);
        nvec++; if (imem_addr !== 32'h100) begin nerr++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
        nvec++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL redir_req got=%b exp=1", imem_req); end
        nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL redir_stale_valid got=%b exp=0", id_valid); end
        for (int unsigned i = 0; i < 20 && !seen; i++) begin
            cyc(0, 1, 0, '0);
            if (id_valid === 1'b1) begin
                seen = 1;
                nvec++; if (id_pc !== 32'h100) begin nerr++; $display("FAIL redir_first_pc got=%h exp=100", id_pc); end
            end
        end
        if (!seen) begin nvec++; nerr++; $display("FAIL redir_first_pc got=timeout exp=delivery"); end
    endtask

    task automatic test_misaligned();
        gnt_all = 0; lat_cfg = 1;
        do_reset();
        cyc(0, 1, 1, 32'h202);
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL mis_req got=%b exp=0", imem_req); end
        cyc(0, 1, 0, '0);
        nvec++; if (imem_addr !== 32'h200) begin nerr++; $display("FAIL mis_addr got=%h exp=200", imem_addr); end
        nvec++; if (redirect_misaligned !== 1'b1) begin nerr++; $display("FAIL mis_pulse got=%b exp=1", redirect_misaligned); end
        cyc(0, 1, 0, '0);
        nvec++; if (redirect_misaligned !== 1'b0) begin nerr++; $display("FAIL mis_clear got=%b exp=0", redirect_misaligned); end
    endtask

    task automatic test_redirect_fill();
        logic [31:0] next_pc;
        int delivered;
        gnt_all = 1; lat_cfg = 1; next_pc = 32'h400; delivered = 0;
        do_reset();
        cyc(0, 1, 0, '0);
        cyc(0, 1, 1, 32'h400);
        nvec++; if (imem_rvalid !== 1'b1) begin nerr++; $display("FAIL rf_setup_rvalid got=%b exp=1", imem_rvalid); end
        cyc(0, 1, 0, '0);
        nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL rf_flush got=%b exp=0", id_valid); end
        nvec++; if (imem_addr !== 32'h400) begin nerr++; $display("FAIL rf_addr got=%h exp=400", imem_addr); end
        for (int unsigned i = 0; i < 10; i++) begin
            cyc(0, 1, 0, '0);
            if (id_valid === 1'b1) begin
                nvec++; if (id_pc !== next_pc) begin nerr++; $display("FAIL rf_seq c=%0d got=%h exp=%h", i, id_pc, next_pc); end
                next_pc += 4; delivered++;
            end
        end
        nvec++; if (delivered == 0) begin nerr++; $display("FAIL rf_deliver got=0 exp>0"); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        gnt_all = 1; lat_cfg = 1; seen = 0;
        do_reset();
        cyc(0, 1, 0, '0);
        cyc(0, 1, 0, '0);
        lat_cfg = 3;
        cyc(0, 1, 0, '0);
        cyc(1, 1, 0, '0);
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL rstmid_req_in_rst got=%b exp=0", imem_req); end
        cyc(0, 1, 0, '0);
        nvec++; if (imem_addr !== RESET_PC) begin nerr++; $display("FAIL rstmid_addr got=%h exp=%h", imem_addr, RESET_PC); end
        nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_valid got=%b exp=0", id_valid); end
        nvec++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL rstmid_req_after got=%b exp=1", imem_req); end
        for (int unsigned i = 0; i < 12 && !seen; i++) begin
            cyc(0, 1, 0, '0);
            if (id_valid === 1'b1) begin
                seen = 1;
                nvec++; if (id_pc !== RESET_PC) begin nerr++; $display("FAIL rstmid_first_pc got=%h exp=%h", id_pc, RESET_PC); end
            end
        end
        if (!seen) begin nvec++; nerr++; $display("FAIL rstmid_first_pc got=timeout exp=delivery"); end
    endtask

    task automatic test_random();
        logic        rs, rdy, rv;
        logic [31:0] rp;
        gnt_all = 0; lat_cfg = 0;
        do_reset();
        for (int unsigned i = 0; i < 600; i++) begin
            rs  = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 7) == 0);
            rp  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
            cyc(rs, rdy, rv, rp);
            nvec++; if (imem_req !== exp_req) begin nerr++; $display("FAIL rnd_req c=%0d got=%b exp=%b", i, imem_req, exp_req); end
            nvec++; if (imem_addr !== m_pc) begin nerr++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", i, imem_addr, m_pc); end
            nvec++; if (id_valid !== buf_valid) begin nerr++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", i, id_valid, buf_valid); end
            nvec++; if (id_instr !== buf_instr) begin nerr++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", i, id_instr, buf_instr); end
            nvec++; if (id_pc !== buf_pc) begin nerr++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", i, id_pc, buf_pc); end
            nvec++; if (redirect_misaligned !== m_mis) begin nerr++; $display("FAIL rnd_mis c=%0d got=%b exp=%b", i, redirect_misaligned, m_mis); end
        end
    endtask

    initial begin
        rst = 1; id_ready = 0; redirect_valid = 0; redirect_pc = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_misaligned();
        test_redirect_fill();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
